shift_register: RTL and testbench

- Parameterised bidirectional shift register built from chained D flip-flop cells. It is the stage directly downstream of the single d_ff: it consumes a bit stream one bit per clock and stores it as a word.
- Supports hold, shift left, shift right and parallel load. Provides a serial output and a word-complete pulse every WIDTH shifts.
- Used as the storage/serialiser stage in the flip-flop chapter's datapath examples.

---
 rtl/shift_register_pkg.sv | 12 +
 rtl/shift_register_d_ff_r.sv | 15 +
 rtl/shift_register.sv | 75 +++++++
 tb/tb_shift_register.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared mode encodings for the shift register and later stages
package shift_register_pkg;

  // Operation select; all four encodings are legal.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_register_d_ff_r.sv
// rtl/shift_register_d_ff_r.sv - D flip-flop with asynchronous active-low reset
module d_ff_r (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; reset clears immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= d;
  end

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - bidirectional shift register with load, serial out and word-complete pulse
module shift_register
  import shift_register_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_next;

  // Next-state mux for the storage cells.
  always_comb begin
    data_next = data_out;
    case (mode)
      MODE_SHL:  data_next = {data_out[WIDTH-2:0], serial_in};
      MODE_SHR:  data_next = {serial_in, data_out[WIDTH-1:1]};
      MODE_LOAD: data_next = load_data;
      default:   data_next = data_out;
    endcase
  end

  // One flip-flop cell per stored bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_r u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (data_next[i]),
      .q       (data_out[i])
    );
  end

  // Serial output, shift counter and word-complete pulse. Both shift
  // directions advance the same count; HOLD freezes it, LOAD aborts the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_out  <= 1'b0;
      shift_count <= '0;
      word_done   <= 1'b0;
    end else begin
      case (mode)
        MODE_SHL, MODE_SHR: begin
          serial_out <= (mode == MODE_SHL) ? data_out[WIDTH-1] : data_out[0];
          if (shift_count == LAST_COUNT) begin
            shift_count <= '0;
            word_done   <= 1'b1;
          end else begin
            shift_count <= shift_count + CNT_W'(1);
            word_done   <= 1'b0;
          end
        end
        MODE_LOAD: begin
          serial_out  <= 1'b0;
          shift_count <= '0;
          word_done   <= 1'b0;
        end
        default: begin
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - directed table-driven bench for shift_register
`timescale 1ns/100ps
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic [2:0]       shift_count;
  logic             word_done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] md;
    logic       sin;
    logic [7:0] ld;
    logic [7:0] exp_d;
    logic       exp_so;
    logic [2:0] exp_cnt;
    logic       exp_wd;
  } vec_t;

  vec_t vecs[$];

  shift_register #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .serial_in   (serial_in),
    .load_data   (load_data),
    .data_out    (data_out),
    .serial_out  (serial_out),
    .shift_count (shift_count),
    .word_done   (word_done)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic so,
                           input logic [2:0] cnt, input logic wd);
    check({tag, " data_out"},    32'(data_out),    32'(d));
    check({tag, " serial_out"},  32'(serial_out),  32'(so));
    check({tag, " shift_count"}, 32'(shift_count), 32'(cnt));
    check({tag, " word_done"},   32'(word_done),   32'(wd));
  endtask

  task automatic step(input logic [1:0] md, input logic sin, input logic [7:0] ld);
    @(negedge clk);
    mode = md;
    serial_in = sin;
    load_data = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] md, input logic sin, input logic [7:0] ld,
                     input logic [7:0] d, input logic so, input logic [2:0] cnt, input logic wd);
    vec_t v;
    v.md = md; v.sin = sin; v.ld = ld;
    v.exp_d = d; v.exp_so = so; v.exp_cnt = cnt; v.exp_wd = wd;
    vecs.push_back(v);
  endtask

  initial begin
    // LOAD then HOLD
    add(MODE_LOAD, 0, 8'hA5, 8'hA5, 0, 0, 0);
    add(MODE_HOLD, 0, 8'h00, 8'hA5, 0, 0, 0);
    add(MODE_HOLD, 0, 8'h00, 8'hA5, 0, 0, 0);
    add(MODE_HOLD, 0, 8'h00, 8'hA5, 0, 0, 0);
    // 8x shift left, serial_in 0
    add(MODE_SHL, 0, 8'h00, 8'h4A, 1, 1, 0);
    add(MODE_SHL, 0, 8'h00, 8'h94, 0, 2, 0);
    add(MODE_SHL, 0, 8'h00, 8'h28, 1, 3, 0);
    add(MODE_SHL, 0, 8'h00, 8'h50, 0, 4, 0);
    add(MODE_SHL, 0, 8'h00, 8'hA0, 0, 5, 0);
    add(MODE_SHL, 0, 8'h00, 8'h40, 1, 6, 0);
    add(MODE_SHL, 0, 8'h00, 8'h80, 0, 7, 0);
    add(MODE_SHL, 0, 8'h00, 8'h00, 1, 0, 1);
    // 8x shift right, serial_in 1
    add(MODE_SHR, 1, 8'h00, 8'h80, 0, 1, 0);
    add(MODE_SHR, 1, 8'h00, 8'hC0, 0, 2, 0);
    add(MODE_SHR, 1, 8'h00, 8'hE0, 0, 3, 0);
    add(MODE_SHR, 1, 8'h00, 8'hF0, 0, 4, 0);
    add(MODE_SHR, 1, 8'h00, 8'hF8, 0, 5, 0);
    add(MODE_SHR, 1, 8'h00, 8'hFC, 0, 6, 0);
    add(MODE_SHR, 1, 8'h00, 8'hFE, 0, 7, 0);
    add(MODE_SHR, 1, 8'h00, 8'hFF, 0, 0, 1);
    add(MODE_HOLD, 0, 8'h00, 8'hFF, 0, 0, 0);
    // Mixed: 4 left, 2 hold, 4 right
    add(MODE_LOAD, 0, 8'h3C, 8'h3C, 0, 0, 0);
    add(MODE_SHL, 1, 8'h00, 8'h79, 0, 1, 0);
    add(MODE_SHL, 1, 8'h00, 8'hF3, 0, 2, 0);
    add(MODE_SHL, 1, 8'h00, 8'hE7, 1, 3, 0);
    add(MODE_SHL, 1, 8'h00, 8'hCF, 1, 4, 0);
    add(MODE_HOLD, 0, 8'h00, 8'hCF, 1, 4, 0);
    add(MODE_HOLD, 0, 8'h00, 8'hCF, 1, 4, 0);
    add(MODE_SHR, 0, 8'h00, 8'h67, 1, 5, 0);
    add(MODE_SHR, 0, 8'h00, 8'h33, 1, 6, 0);
    add(MODE_SHR, 0, 8'h00, 8'h19, 1, 7, 0);
    add(MODE_SHR, 0, 8'h00, 8'h0C, 1, 0, 1);
    add(MODE_SHL, 0, 8'h00, 8'h18, 0, 1, 0);
    // LOAD aborts a word in progress
    add(MODE_LOAD, 0, 8'h81, 8'h81, 0, 0, 0);
    add(MODE_SHL, 1, 8'h00, 8'h03, 1, 1, 0);

    // Reset state
    #5;
    check_all("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].md, vecs[i].sin, vecs[i].ld);
      check_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_so,
                vecs[i].exp_cnt, vecs[i].exp_wd);
    end

    // Asynchronous reset between edges
    step(MODE_LOAD, 0, 8'hFF);
    step(MODE_SHL, 1, 8'h00);
    check_all("pre_async", 8'hFF, 1, 1, 0);
    @(negedge clk);
    mode = MODE_HOLD;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 0, 0, 0);
    reset_n = 1'b1;

    // Reset mid-word restarts the word count
    for (int i = 0; i < 5; i++) step(MODE_SHL, 0, 8'h00);
    check("midword cnt5", 32'(shift_count), 32'd5);
    @(negedge clk);
    mode = MODE_HOLD;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    check("midword cleared", 32'(shift_count), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      step(MODE_SHR, 0, 8'h00);
      check($sformatf("post_reset cnt%0d", i), 32'(shift_count), 32'(i));
      check($sformatf("post_reset wd%0d", i), 32'(word_done), 32'd0);
    end
    step(MODE_SHR, 0, 8'h00);
    check("post_reset wd8", 32'(word_done), 32'd1);
    check("post_reset cnt8", 32'(shift_count), 32'd0);
    step(MODE_HOLD, 0, 8'h00);
    check("post_reset wd clear", 32'(word_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
